mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory stage of the 16-bit pipeline; sits directly downstream of EX.
//  Registers EX results (EX/MEM register), resolves taken branches, and performs
//  data-memory loads/stores of MEM_LAT cycles, stalling upstream while busy.
//  Produces registered MEM/WB outputs for the writeback stage.
// PARAMETERS
//  DATA_W   16  data/address word width
//  ADDR_W   8   data-memory address bits (depth 2**ADDR_W words)
//  MEM_LAT  2   cycles per memory access, legal range 1..15
// PORTS
//  clock          in   1       single clock, rising edge
//  reset_n        in   1       asynchronous, active-low reset
//  in_valid       in   1       EX presents a valid instruction
//  in_Branch      in   1       branch instruction
//  in_Zero        in   1       ALU Zero flag from EX
//  in_MemRead     in   1       load
//  in_MemWrite    in   1       store
//  in_RegWrite    in   1       instruction writes register file
//  in_MemToReg    in   1       writeback selects load data (1) or ALU result (0)
//  in_rd          in   3       destination register
//  in_jumpResult  in   DATA_W  branch target from EX
//  in_outputALU   in   DATA_W  ALU result / memory address
//  in_writeData   in   DATA_W  store data
//  flush          in   1       kill instruction being captured this edge
//  stall          out  1       upstream must hold its outputs
//  PCSrc          out  1       taken branch
//  branchTarget   out  DATA_W  PC for the taken branch
//  wb_valid       out  1       MEM/WB entry valid
//  wb_RegWrite    out  1
//  wb_rd          out  3
//  wb_data        out  DATA_W  selected writeback value
// BEHAVIOUR
//  - Reset (async): state IDLE, cnt 0, stage valid 0, all outputs 0. Memory
//    contents are not reset. Reset mid-access abandons it; a pending store is not written.
//  - Capture: on each edge with stall=0, stage reg <= in_*; stage valid <= in_valid & ~flush.
//    flush only kills the capture; it never aborts an access already in BUSY.
//  - States: IDLE, BUSY. A valid stage entry with MemRead|MemWrite captured at edge E0
//    -> BUSY, cnt=MEM_LAT-1. In BUSY, cnt decrements each edge. Completion edge is
//    the edge where cnt==0: access is performed, wb_* is registered, and the FSM
//    returns to IDLE (or re-enters BUSY if a new memory op is captured on that same edge).
//  - stall = (state==BUSY) && (cnt!=0). A load/store completes at edge E0+MEM_LAT.
//    The next instruction is captured at the completion edge (no bubble).
//  - Non-memory instruction captured at E0: wb_* registered at E0+1.
//  - Address = stage outputALU[ADDR_W-1:0]; upper bits ignored (wrap-around).
//    Store writes writeData at the completion edge. Load data = mem[addr] read at the
//    completion edge. Write-then-read of the same address returns the new value.
//  - wb_data = MemToReg ? load data : outputALU. Store: wb_valid=1, wb_RegWrite=0.
//    wb_valid=0 on any edge where no instruction completes.
//  - PCSrc = stage valid & Branch & Zero, combinational from the stage reg, high one cycle.
//    branchTarget = stage jumpResult (0 when PCSrc=0).
//    Branch with MemRead|MemWrite is illegal; the memory op proceeds and PCSrc still fires.
//  - A flushed or invalid stage entry produces no memory access, no PCSrc, and no wb.
// CONFIGURATION
//  MEM_STAGE_FWD_EN defined: adds outputs fwd_valid(1), fwd_rd(3), fwd_data(DATA_W)
//    driven combinationally from the stage reg:
//    fwd_valid = valid & RegWrite & ~MemRead, fwd_data = outputALU, for EX forwarding.
//  Undefined: the ports do not exist, and there is no related logic.
// TESTING
//  1 ALU op rd=3, ALU=0x1234, RegWrite=1, MemToReg=0 -> wb_valid=1, wb_rd=3,
//    wb_data=0x1234 one cycle after capture; stall=0 throughout.
//  2 Store 0xBEEF @0x0105, then load @0x0005, MemToReg=1, MEM_LAT=2 -> stall=1 for one
//    cycle per op; the load returns 0xBEEF (address wrap) at E0+2.
//  3 Branch=1, Zero=1, jumpResult=0x0040 -> PCSrc=1 for exactly one cycle with
//    branchTarget=0x0040. Zero=0 -> PCSrc stays 0.
//  4 flush=1 on the capture of a store to 0x10 -> no stall, wb_valid=0, and a later
//    load @0x10 does not return that store's data.
//  5 reset_n low during the BUSY state of a store -> all outputs 0 immediately;
//    memory location unchanged.
//  6 Back-to-back loads with MEM_LAT=1 -> one wb per cycle, stall never asserted.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage of the 16-bit pipeline: EX/MEM register, branch resolve, multi-cycle data memory, MEM/WB register.
// Optional EX forwarding outputs are enabled by defining MEM_STAGE_FWD_EN.
module mem_stage #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              in_Branch,
  input  logic              in_Zero,
  input  logic              in_MemRead,
  input  logic              in_MemWrite,
  input  logic              in_RegWrite,
  input  logic              in_MemToReg,
  input  logic [2:0]        in_rd,
  input  logic [DATA_W-1:0] in_jumpResult,
  input  logic [DATA_W-1:0] in_outputALU,
  input  logic [DATA_W-1:0] in_writeData,
  input  logic              flush,
  output logic              stall,
  output logic              PCSrc,
  output logic [DATA_W-1:0] branchTarget,
`ifdef MEM_STAGE_FWD_EN
  output logic              fwd_valid,
  output logic [2:0]        fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              wb_valid,
  output logic              wb_RegWrite,
  output logic [2:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, stateNext;
  logic [3:0] cnt, cntNext;

  logic              vld_p0;
  logic              branch_p0, zero_p0, memRead_p0, memWrite_p0;
  logic              regWrite_p0, memToReg_p0;
  logic [2:0]        rd_p0;
  logic [DATA_W-1:0] jumpResult_p0, outputALU_p0, writeData_p0;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] loadData;
  logic              complete;
  logic              captureMem;

  // The stage entry retires on any edge where it is valid and not held by a pending access.
  always_comb begin
    stall      = (state == BUSY) && (cnt != 4'd0);
    complete   = vld_p0 && !stall;
    captureMem = !stall && in_valid && !flush && (in_MemRead || in_MemWrite);
    addr_p0    = outputALU_p0[ADDR_W-1:0];
    loadData   = mem[addr_p0];
    PCSrc        = vld_p0 && branch_p0 && zero_p0;
    branchTarget = PCSrc ? jumpResult_p0 : '0;
  end

`ifdef MEM_STAGE_FWD_EN
  always_comb begin
    fwd_valid = vld_p0 && regWrite_p0 && !memRead_p0;
    fwd_rd    = rd_p0;
    fwd_data  = outputALU_p0;
  end
`endif

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    if (captureMem) begin
      stateNext = BUSY;
      cntNext   = CNT_INIT;
    end else if ((state == BUSY) && (cnt != 4'd0)) begin
      cntNext = cnt - 4'd1;
    end else begin
      stateNext = IDLE;
      cntNext   = 4'd0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // EX/MEM boundary: valid is reset, the payload is not.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0 <= 1'b0;
    end else if (!stall) begin
      vld_p0 <= in_valid && !flush;
    end
  end

  always_ff @(posedge clock) begin
    if (!stall) begin
      branch_p0     <= in_Branch;
      zero_p0       <= in_Zero;
      memRead_p0    <= in_MemRead;
      memWrite_p0   <= in_MemWrite;
      regWrite_p0   <= in_RegWrite;
      memToReg_p0   <= in_MemToReg;
      rd_p0         <= in_rd;
      jumpResult_p0 <= in_jumpResult;
      outputALU_p0  <= in_outputALU;
      writeData_p0  <= in_writeData;
    end
  end

  always_ff @(posedge clock) begin
    if (complete && memWrite_p0) begin
      mem[addr_p0] <= writeData_p0;
    end
  end

  // MEM/WB boundary: every output clears on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid    <= 1'b0;
      wb_RegWrite <= 1'b0;
      wb_rd       <= 3'd0;
      wb_data     <= '0;
    end else begin
      wb_valid <= complete;
      if (complete) begin
        wb_RegWrite <= regWrite_p0;
        wb_rd       <= rd_p0;
        wb_data     <= memToReg_p0 ? loadData : outputALU_p0;
      end else begin
        wb_RegWrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: one instance at MEM_LAT=2 and one at MEM_LAT=1 sharing the input bus.
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_Branch, in_Zero, in_MemRead, in_MemWrite;
  logic        in_RegWrite, in_MemToReg, flush;
  logic [2:0]  in_rd;
  logic [15:0] in_jumpResult, in_outputALU, in_writeData;

  logic        stall, PCSrc, wb_valid, wb_RegWrite;
  logic [15:0] branchTarget, wb_data;
  logic [2:0]  wb_rd;
  logic        stall1, PCSrc1, wb_valid1, wb_RegWrite1;
  logic [15:0] branchTarget1, wb_data1;
  logic [2:0]  wb_rd1;
`ifdef MEM_STAGE_FWD_EN
  logic        fwd_valid, fwd_valid1;
  logic [2:0]  fwd_rd, fwd_rd1;
  logic [15:0] fwd_data, fwd_data1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_stage #(.DATA_W(16), .ADDR_W(8), .MEM_LAT(2)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_Branch(in_Branch),
    .in_Zero(in_Zero), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
    .in_RegWrite(in_RegWrite), .in_MemToReg(in_MemToReg), .in_rd(in_rd),
    .in_jumpResult(in_jumpResult), .in_outputALU(in_outputALU), .in_writeData(in_writeData),
    .flush(flush), .stall(stall), .PCSrc(PCSrc), .branchTarget(branchTarget),
`ifdef MEM_STAGE_FWD_EN
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
    .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  mem_stage #(.DATA_W(16), .ADDR_W(8), .MEM_LAT(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_Branch(in_Branch),
    .in_Zero(in_Zero), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
    .in_RegWrite(in_RegWrite), .in_MemToReg(in_MemToReg), .in_rd(in_rd),
    .in_jumpResult(in_jumpResult), .in_outputALU(in_outputALU), .in_writeData(in_writeData),
    .flush(flush), .stall(stall1), .PCSrc(PCSrc1), .branchTarget(branchTarget1),
`ifdef MEM_STAGE_FWD_EN
    .fwd_valid(fwd_valid1), .fwd_rd(fwd_rd1), .fwd_data(fwd_data1),
`endif
    .wb_valid(wb_valid1), .wb_RegWrite(wb_RegWrite1), .wb_rd(wb_rd1), .wb_data(wb_data1)
  );

  typedef struct packed {
    logic        v, br, z, mr, mw, rw, m2r, fl;
    logic [2:0]  rd;
    logic [15:0] jr, alu, wd;
    logic        eSt, ePc;
    logic [15:0] eTgt;
    logic        eWbv, eWbrw;
    logic [2:0]  eRd;
    logic [15:0] eData;
  } vec_t;

  function automatic vec_t mk(
    input logic v, br, z, mr, mw, rw, m2r, fl,
    input logic [2:0] rd, input logic [15:0] jr, alu, wd,
    input logic eSt, ePc, input logic [15:0] eTgt,
    input logic eWbv, eWbrw, input logic [2:0] eRd, input logic [15:0] eData);
    vec_t t;
    t.v = v; t.br = br; t.z = z; t.mr = mr; t.mw = mw; t.rw = rw; t.m2r = m2r; t.fl = fl;
    t.rd = rd; t.jr = jr; t.alu = alu; t.wd = wd;
    t.eSt = eSt; t.ePc = ePc; t.eTgt = eTgt;
    t.eWbv = eWbv; t.eWbrw = eWbrw; t.eRd = eRd; t.eData = eData;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    in_valid = t.v;  in_Branch = t.br;  in_Zero = t.z;  in_MemRead = t.mr;
    in_MemWrite = t.mw;  in_RegWrite = t.rw;  in_MemToReg = t.m2r;  flush = t.fl;
    in_rd = t.rd;  in_jumpResult = t.jr;  in_outputALU = t.alu;  in_writeData = t.wd;
  endtask

  task automatic applyVec(input vec_t t, input bit lat1, input int idx);
    logic aSt, aPc, aWbv, aWbrw;
    logic [15:0] aTgt, aData;
    logic [2:0] aRd;
    string p;
    drive(t);
    @(posedge clock);
    #1;
    if (lat1) begin
      p = "lat1_";
      aSt = stall1; aPc = PCSrc1; aTgt = branchTarget1; aWbv = wb_valid1;
      aWbrw = wb_RegWrite1; aRd = wb_rd1; aData = wb_data1;
    end else begin
      p = "lat2_";
      aSt = stall; aPc = PCSrc; aTgt = branchTarget; aWbv = wb_valid;
      aWbrw = wb_RegWrite; aRd = wb_rd; aData = wb_data;
    end
    chk({p, "stall"}, idx, 16'(aSt), 16'(t.eSt));
    chk({p, "PCSrc"}, idx, 16'(aPc), 16'(t.ePc));
    chk({p, "branchTarget"}, idx, aTgt, t.eTgt);
    chk({p, "wb_valid"}, idx, 16'(aWbv), 16'(t.eWbv));
    if (t.eWbv) begin
      chk({p, "wb_RegWrite"}, idx, 16'(aWbrw), 16'(t.eWbrw));
      chk({p, "wb_rd"}, idx, 16'(aRd), 16'(t.eRd));
      chk({p, "wb_data"}, idx, aData, t.eData);
    end
  endtask

  task automatic chkAllZero(input int idx);
    chk("rst_stall", idx, 16'(stall), 16'h0);
    chk("rst_PCSrc", idx, 16'(PCSrc), 16'h0);
    chk("rst_branchTarget", idx, branchTarget, 16'h0);
    chk("rst_wb_valid", idx, 16'(wb_valid), 16'h0);
    chk("rst_wb_RegWrite", idx, 16'(wb_RegWrite), 16'h0);
    chk("rst_wb_rd", idx, 16'(wb_rd), 16'h0);
    chk("rst_wb_data", idx, wb_data, 16'h0);
    chk("rst_lat1_stall", idx, 16'(stall1), 16'h0);
    chk("rst_lat1_wb_valid", idx, 16'(wb_valid1), 16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tblA[19];
    vec_t tblB[6];
    vec_t nop;
    nop = mk(0,0,0,0,0,0,0,0, 3'd0, 16'h0, 16'h0, 16'h0, 0,0,16'h0, 0,0,3'd0,16'h0);

    // MEM_LAT=2: ALU op, store/load with address wrap, branches, flushed store, flushed ALU op
    tblA[0]  = mk(1,0,0,0,0,1,0,0, 3'd3, 16'h0, 16'h1234, 16'h0,    0,0,16'h0,    0,0,3'd0,16'h0);
    tblA[1]  = mk(0,0,0,0,0,0,0,0, 3'd0, 16'h0, 16'h0,    16'h0,    0,0,16'h0,    1,1,3'd3,16'h1234);
    tblA[2]  = mk(1,0,0,0,1,0,0,0, 3'd0, 16'h0, 16'h0105, 16'hBEEF, 1,0,16'h0,    0,0,3'd0,16'h0);
    tblA[3]  = mk(1,0,0,1,0,1,1,0, 3'd5, 16'h0, 16'h0005, 16'h0,    0,0,16'h0,    0,0,3'd0,16'h0);
    tblA[4]  = mk(1,0,0,1,0,1,1,0, 3'd5, 16'h0, 16'h0005, 16'h0,    1,0,16'h0,    1,0,3'd0,16'h0105);
    tblA[5]  = nop;
    tblA[6]  = mk(0,0,0,0,0,0,0,0, 3'd0, 16'h0, 16'h0,    16'h0,    0,0,16'h0,    1,1,3'd5,16'hBEEF);
    tblA[7]  = mk(1,1,1,0,0,0,0,0, 3'd0, 16'h0040, 16'h0, 16'h0,    0,1,16'h0040, 0,0,3'd0,16'h0);
    tblA[8]  = mk(0,0,0,0,0,0,0,0, 3'd0, 16'h0, 16'h0,    16'h0,    0,0,16'h0,    1,0,3'd0,16'h0);
    tblA[9]  = mk(1,1,0,0,0,0,0,0, 3'd0, 16'h0080, 16'h0, 16'h0,    0,0,16'h0,    0,0,3'd0,16'h0);
    tblA[10] = mk(1,0,0,0,1,0,0,0, 3'd0, 16'h0, 16'h0010, 16'h1111, 1,0,16'h0,    1,0,3'd0,16'h0);
    tblA[11] = nop;
    tblA[12] = mk(1,0,0,0,1,0,0,1, 3'd0, 16'h0, 16'h0010, 16'hDEAD, 0,0,16'h0,    1,0,3'd0,16'h0010);
    tblA[13] = nop;
    tblA[14] = mk(1,0,0,1,0,1,1,0, 3'd2, 16'h0, 16'h0010, 16'h0,    1,0,16'h0,    0,0,3'd0,16'h0);
    tblA[15] = nop;
    tblA[16] = mk(0,0,0,0,0,0,0,0, 3'd0, 16'h0, 16'h0,    16'h0,    0,0,16'h0,    1,1,3'd2,16'h1111);
    tblA[17] = mk(1,0,0,0,0,1,0,1, 3'd6, 16'h0, 16'h5555, 16'h0,    0,0,16'h0,    0,0,3'd0,16'h0);
    tblA[18] = nop;

    // MEM_LAT=1: back-to-back stores then loads, one writeback per cycle, no stall
    tblB[0] = mk(1,0,0,0,1,0,0,0, 3'd0, 16'h0, 16'h0040, 16'hA5A5, 0,0,16'h0, 0,0,3'd0,16'h0);
    tblB[1] = mk(1,0,0,0,1,0,0,0, 3'd0, 16'h0, 16'h0041, 16'h5A5A, 0,0,16'h0, 1,0,3'd0,16'h0040);
    tblB[2] = mk(1,0,0,1,0,1,1,0, 3'd1, 16'h0, 16'h0040, 16'h0,    0,0,16'h0, 1,0,3'd0,16'h0041);
    tblB[3] = mk(1,0,0,1,0,1,1,0, 3'd2, 16'h0, 16'h0041, 16'h0,    0,0,16'h0, 1,1,3'd1,16'hA5A5);
    tblB[4] = mk(0,0,0,0,0,0,0,0, 3'd0, 16'h0, 16'h0,    16'h0,    0,0,16'h0, 1,1,3'd2,16'h5A5A);
    tblB[5] = nop;

    drive(nop);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chkAllZero(0);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) applyVec(tblA[i], 1'b0, i);

    // Reset during BUSY of a store: outputs clear at once, location keeps its old value
    applyVec(mk(1,0,0,0,1,0,0,0, 3'd0, 16'h0, 16'h0030, 16'h2222, 1,0,16'h0, 0,0,3'd0,16'h0), 1'b0, 100);
    applyVec(nop, 1'b0, 101);
    applyVec(mk(1,0,0,0,1,0,0,0, 3'd0, 16'h0, 16'h0030, 16'h9999, 1,0,16'h0, 1,0,3'd0,16'h0030), 1'b0, 102);
    #2;
    reset_n = 1'b0;
    #1;
    chkAllZero(103);
    drive(nop);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    applyVec(mk(1,0,0,1,0,1,1,0, 3'd4, 16'h0, 16'h0030, 16'h0, 1,0,16'h0, 0,0,3'd0,16'h0), 1'b0, 104);
    applyVec(nop, 1'b0, 105);
    applyVec(mk(0,0,0,0,0,0,0,0, 3'd0, 16'h0, 16'h0, 16'h0, 0,0,16'h0, 1,1,3'd4,16'h2222), 1'b0, 106);

    for (int i = 0; i < 6; i++) applyVec(tblB[i], 1'b1, 200 + i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
